// File: rtl/router_port_grant_arb_if.sv
// Bundle between the router's combinational port-request logic, the flit
// source of the granted port, the downstream link and the grant stage.
//
// Flit handshake: a flit moves on a rising clk edge exactly when
// flit_valid_i and link_ready_i are both high while a grant is valid.
// flit_tail_i is only meaningful in such a cycle. Neither side may make
// flit_valid_i or link_ready_i depend combinationally on the other.
interface router_port_grant_arb_if #(
  parameter int NPORT = 4,
  parameter int SEL_W = 2
);
  logic [NPORT-1:0] req_i;
  logic [1:0]       hp_i;
  logic             flit_valid_i;
  logic             flit_tail_i;
  logic             link_ready_i;
  logic [NPORT-1:0] gnt_o;
  logic             gnt_valid_o;
  logic [SEL_W-1:0] sel_o;
  logic             busy_o;
  logic             timeout_o;
  logic [1:0]       state_dbg;

  // Requesting/flit side drives the inputs and watches the grant.
  modport master (
    output req_i, hp_i, flit_valid_i, flit_tail_i, link_ready_i,
    input  gnt_o, gnt_valid_o, sel_o, busy_o, timeout_o, state_dbg
  );

  // Grant stage.
  modport slave (
    input  req_i, hp_i, flit_valid_i, flit_tail_i, link_ready_i,
    output gnt_o, gnt_valid_o, sel_o, busy_o, timeout_o, state_dbg
  );
endinterface

// File: rtl/router_port_grant_arb.sv
// Sequential grant stage for one router output link. Picks one requesting
// input port (fixed priority for the two high-priority ports, otherwise
// round-robin), holds that grant across a whole packet, and revokes grants
// that never begin transferring. All outputs are registered.
module router_port_grant_arb #(
  parameter int NPORT       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input logic                  clk,
  input logic                  rst,
  router_port_grant_arb_if.slave arb
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic [NPORT-1:0] gnt;
  logic             gnt_valid;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  logic             xfer;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] idx;
  logic             found;

  assign xfer = arb.flit_valid_i & arb.link_ready_i;

  // Winner search: high-priority ports 0 then 1, else first requester from rr_ptr.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (arb.hp_i[0] && arb.req_i[0]) begin
      win   = SEL_W'(0);
      found = 1'b1;
    end else if (arb.hp_i[1] && arb.req_i[1]) begin
      win   = SEL_W'(1);
      found = 1'b1;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        idx = rr_ptr + SEL_W'(i);
        if (!found && arb.req_i[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  // Grant FSM with registered outputs; rr_ptr advances on every release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      sel       <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb.req_i) begin
            gnt       <= {{(NPORT-1){1'b0}}, 1'b1} << win;
            sel       <= win;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            wait_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A transfer outranks both a cancelled request and the timeout.
          if (xfer && arb.flit_tail_i) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= sel + SEL_W'(1);
            state     <= RELEASE;
          end else if (xfer) begin
            state <= XFER;
          end else if (!arb.req_i[sel]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= sel + SEL_W'(1);
            state     <= RELEASE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b1;
            rr_ptr    <= sel + SEL_W'(1);
            state     <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        XFER: begin
          // Packet in flight: grant is locked until the tail is accepted.
          if (xfer && arb.flit_tail_i) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            rr_ptr    <= sel + SEL_W'(1);
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign arb.gnt_o       = gnt;
  assign arb.gnt_valid_o = gnt_valid;
  assign arb.sel_o       = sel;
  assign arb.busy_o      = busy;
  assign arb.timeout_o   = timeout;
  assign arb.state_dbg   = state;

endmodule

// File: tb/tb_router_port_grant_arb.sv
// Directed bench for router_port_grant_arb (TIMEOUT_CYC=4). Expected grant
// vectors go into exp_q when a request pattern is driven; a negedge monitor
// pops one entry each time a new grant appears. Cycle-level expectations
// (holds, gaps, timeout pulse, reset) are checked inline.
module tb_router_port_grant_arb;

  localparam int NPORT = 4;
  localparam int SEL_W = 2;

  logic clk;
  logic rst;

  router_port_grant_arb_if #(.NPORT(NPORT), .SEL_W(SEL_W)) bus ();

  router_port_grant_arb #(
    .NPORT(NPORT), .SEL_W(SEL_W), .TIMEOUT_CYC(4), .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus.slave)
  );

  logic [NPORT-1:0] exp_q[$];
  int n_cmp;
  int n_err;
  logic prev_gv;

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flit(input logic v, input logic t, input logic r);
    bus.flit_valid_i = v;
    bus.flit_tail_i  = t;
    bus.link_ready_i = r;
  endtask

  task automatic expect_grant(input logic [NPORT-1:0] g);
    exp_q.push_back(g);
  endtask

  // Scoreboard monitor: each new grant must match the next expected vector.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot0", {31'b0, $onehot0(bus.gnt_o)}, 32'd1);
      if (bus.gnt_valid_o && !prev_gv) begin
        chk("gnt_nonzero", {31'b0, |bus.gnt_o}, 32'd1);
        if (exp_q.size() == 0) chk("gnt_unexpected", {28'b0, bus.gnt_o}, 32'd0);
        else chk("gnt_order", {28'b0, bus.gnt_o}, {28'b0, exp_q.pop_front()});
      end
    end
    prev_gv = bus.gnt_valid_o;
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    prev_gv = 1'b0;
    rst     = 1'b1;
    bus.req_i = '0;
    bus.hp_i  = '0;
    drive_flit(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // 1: reset values, then idle with no requests
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_gnt_valid", bus.gnt_valid_o, 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_quiet", {bus.busy_o, bus.timeout_o, bus.gnt_o}, 0);
    end

    // 2: round-robin from rr_ptr=0, single-flit packets
    bus.req_i = 4'b1010;
    expect_grant(4'b0010);
    tick();
    chk("t2_sel1", bus.sel_o, 1);
    drive_flit(1'b1, 1'b1, 1'b1);
    tick();
    drive_flit(1'b0, 1'b0, 1'b0);
    chk("t2_release_gv", bus.gnt_valid_o, 0);
    chk("t2_release_busy", bus.busy_o, 1);
    expect_grant(4'b1000);
    tick();
    chk("t2_idle_busy", bus.busy_o, 0);
    chk("t2_sel_hold", bus.sel_o, 1);
    tick();
    chk("t2_sel3", bus.sel_o, 3);
    drive_flit(1'b1, 1'b1, 1'b1);
    tick();
    drive_flit(1'b0, 1'b0, 1'b0);
    bus.req_i = '0;
    tick();

    // 3: cancel to set rr_ptr=2, then hp port0 wins, then rr from 1
    bus.req_i = 4'b0010;
    expect_grant(4'b0010);
    tick();
    bus.req_i = 4'b0000;
    tick();
    chk("t3_cancel_gv", bus.gnt_valid_o, 0);
    chk("t3_cancel_no_to", bus.timeout_o, 0);
    bus.req_i = 4'b1101;
    bus.hp_i  = 2'b01;
    expect_grant(4'b0001);
    tick();
    tick();
    chk("t3_hp_sel0", bus.sel_o, 0);
    drive_flit(1'b1, 1'b1, 1'b1);
    tick();
    drive_flit(1'b0, 1'b0, 1'b0);
    bus.hp_i = 2'b00;
    expect_grant(4'b0100);
    tick();
    tick();
    chk("t3_rr_sel2", bus.sel_o, 2);

    // 4: 3-flit packet on port2, link_ready toggling, request dropped after head
    drive_flit(1'b1, 1'b0, 1'b1);
    tick();
    bus.req_i = 4'b1001;
    drive_flit(1'b1, 1'b0, 1'b0);
    tick();
    chk("t4_hold_stall1", bus.gnt_o, 4'b0100);
    drive_flit(1'b1, 1'b0, 1'b1);
    tick();
    chk("t4_hold_body", bus.gnt_o, 4'b0100);
    drive_flit(1'b1, 1'b1, 1'b0);
    tick();
    chk("t4_hold_stall2", bus.gnt_o, 4'b0100);
    chk("t4_hold_busy", bus.busy_o, 1);
    drive_flit(1'b1, 1'b1, 1'b1);
    tick();
    drive_flit(1'b0, 1'b0, 1'b0);
    chk("t4_gap_gnt", bus.gnt_o, 0);
    chk("t4_gap_gv", bus.gnt_valid_o, 0);
    expect_grant(4'b1000);
    tick();
    chk("t4_idle_gnt", bus.gnt_o, 0);
    tick();

    // 5: port3 granted, never transfers -> revoked after 4 cycles
    chk("t5_to_gnt0", bus.gnt_o, 4'b1000);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t5_to_gnt", bus.gnt_o, 4'b1000);
      chk("t5_to_nopulse", bus.timeout_o, 0);
    end
    tick();
    chk("t5_revoke_gnt", bus.gnt_o, 0);
    chk("t5_timeout_pulse", bus.timeout_o, 1);
    bus.req_i = '0;
    tick();
    chk("t5_pulse_end", bus.timeout_o, 0);
    bus.req_i = 4'b1111;
    expect_grant(4'b0001);
    tick();
    chk("t5_rr0_sel", bus.sel_o, 0);

    // 6: reset while in XFER, then grant again right after release of reset
    drive_flit(1'b1, 1'b0, 1'b1);
    tick();
    chk("t6_xfer_busy", bus.busy_o, 1);
    chk("t6_xfer_state", bus.state_dbg, 2);
    rst = 1'b1;
    drive_flit(1'b0, 1'b0, 1'b0);
    bus.req_i = '0;
    tick();
    chk("t6_rst_gnt", bus.gnt_o, 0);
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_sel", bus.sel_o, 0);
    chk("t6_rst_timeout", bus.timeout_o, 0);
    chk("t6_rst_gv", bus.gnt_valid_o, 0);
    rst = 1'b0;
    bus.req_i = 4'b0001;
    expect_grant(4'b0001);
    tick();
    chk("t6_regrant", bus.gnt_o, 4'b0001);
    drive_flit(1'b1, 1'b1, 1'b1);
    tick();
    drive_flit(1'b0, 1'b0, 1'b0);
    bus.req_i = '0;
    tick();
    tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
